// File: rtl/rlbp_seq_pkg.sv
// rtl/rlbp_seq_pkg.sv - shared types and constants for the RLBP phase sequencer
package rlbp_seq_pkg;

    localparam int NCH_DEF = 6;
    localparam int TW_DEF  = 11;
    localparam int CW_DEF  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // phase_out[k] drives pixel pin out_<CH_OUT_NUM[k]>; out_6 does not exist
    localparam int CH_OUT_NUM [NCH_DEF] = '{1, 2, 3, 4, 5, 7};

    function automatic int ch_out_num(input int k);
        return CH_OUT_NUM[k];
    endfunction

endpackage

// File: rtl/rlbp_phase_window.sv
// rtl/rlbp_phase_window.sv - registered up/down window comparator for one phase channel
module rlbp_phase_window
    import rlbp_seq_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          en,
    input  logic [TW-1:0] up,
    input  logic [TW-1:0] down,
    input  logic [CW-1:0] cnt,
    output logic          win
);

    logic [CW-1:0] up_ext;
    logic [CW-1:0] down_ext;

    assign up_ext   = CW'(up);
    assign down_ext = CW'(down);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            win <= 1'b0;
        end else begin
            win <= en && (up_ext <= cnt) && (cnt < down_ext);
        end
    end

endmodule

// File: rtl/rlbp_phase_sequencer.sv
// rtl/rlbp_phase_sequencer.sv - frame timing FSM driving pixel reset and phase windows
module rlbp_phase_sequencer
    import rlbp_seq_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int TW  = TW_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH*TW-1:0] time_up,
    input  logic [NCH*TW-1:0] time_down,
    input  logic [CW-1:0]     count,
    input  logic [CW-1:0]     q,
    output logic              rst_o,
    output logic [NCH-1:0]    phase_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CW-1:0]     frame_idx
);

    seq_state_t state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CW-1:0]     frame, frame_n;
    logic [CW-1:0]     len_sh, len_n;
    logic [CW-1:0]     rep_sh, rep_n;
    logic [NCH*TW-1:0] up_sh, up_n;
    logic [NCH*TW-1:0] down_sh, down_n;
    logic              bad_cfg;
    logic              frame_end;
    logic              last_frame;
    logic              err_n;

    assign bad_cfg    = (count == '0) || (q == '0);
    assign frame_end  = (cnt == len_sh - CW'(1));
    assign last_frame = (frame == rep_sh - CW'(1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = frame;
        len_n   = len_sh;
        rep_n   = rep_sh;
        up_n    = up_sh;
        down_n  = down_sh;
        err_n   = 1'b0;
        if (abort) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            frame_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state_n = ST_LOAD;
                end
                ST_LOAD: begin
                    len_n   = count;
                    rep_n   = q;
                    up_n    = time_up;
                    down_n  = time_down;
                    cnt_n   = '0;
                    frame_n = '0;
                    if (bad_cfg) begin
                        state_n = ST_IDLE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_end) begin
                        cnt_n = '0;
                        if (last_frame) begin
                            state_n = ST_DONE;
                            frame_n = '0;
                        end else begin
                            frame_n = frame + CW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            frame     <= '0;
            len_sh    <= '0;
            rep_sh    <= '0;
            up_sh     <= '0;
            down_sh   <= '0;
            rst_o     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_idx <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame     <= frame_n;
            len_sh    <= len_n;
            rep_sh    <= rep_n;
            up_sh     <= up_n;
            down_sh   <= down_n;
            rst_o     <= (state_n == ST_RUN) && (cnt_n == '0);
            busy      <= (state_n != ST_IDLE);
            done      <= (state_n == ST_DONE);
            err       <= err_n;
            frame_idx <= frame_n;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        rlbp_phase_window #(
            .TW (TW),
            .CW (CW)
        ) u_win (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .en       (state_n == ST_RUN),
            .up       (up_n[k*TW +: TW]),
            .down     (down_n[k*TW +: TW]),
            .cnt      (cnt_n),
            .win      (phase_out[k])
        );
    end

endmodule

// File: tb/tb_rlbp_phase_sequencer.sv
// tb/tb_rlbp_phase_sequencer.sv - scoreboard bench for rlbp_phase_sequencer
module tb_rlbp_phase_sequencer;

    localparam int NCH = 6;
    localparam int TW  = 11;
    localparam int CW  = 12;

    typedef struct {
        logic           rst_o;
        logic [NCH-1:0] phase;
        logic           busy;
        logic           done;
        logic           err;
        logic           run;
        logic [CW-1:0]  fidx;
    } rec_t;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b1;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [NCH*TW-1:0] time_up  = '0;
    logic [NCH*TW-1:0] time_down = '0;
    logic [CW-1:0]     count    = '0;
    logic [CW-1:0]     q        = '0;
    logic              rst_o;
    logic [NCH-1:0]    phase_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [CW-1:0]     frame_idx;

    rec_t exp_q[$];
    rec_t tl[$];
    bit   loading = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rlbp_phase_sequencer #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .abort     (abort),
        .time_up   (time_up),
        .time_down (time_down),
        .count     (count),
        .q         (q),
        .rst_o     (rst_o),
        .phase_out (phase_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .frame_idx (frame_idx)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic rec_t idle_rec();
        rec_t r;
        r.rst_o = 1'b0;
        r.phase = '0;
        r.busy  = 1'b0;
        r.done  = 1'b0;
        r.err   = 1'b0;
        r.run   = 1'b0;
        r.fidx  = '0;
        return r;
    endfunction

    // Whole-run timeline derived from the latched configuration
    task automatic build_run();
        rec_t r;
        int n, m, c, u, d;
        n = int'(count);
        m = int'(q);
        if (n == 0 || m == 0) begin
            r = idle_rec();
            r.err = 1'b1;
            tl.push_back(r);
            return;
        end
        for (int i = 0; i < n * m; i++) begin
            c = i % n;
            r = idle_rec();
            r.run   = 1'b1;
            r.busy  = 1'b1;
            r.rst_o = (c == 0);
            r.fidx  = CW'(i / n);
            for (int k = 0; k < NCH; k++) begin
                u = int'(time_up[k*TW +: TW]);
                d = int'(time_down[k*TW +: TW]);
                r.phase[k] = (u <= c) && (c < d);
            end
            tl.push_back(r);
        end
        r = idle_rec();
        r.busy = 1'b1;
        r.done = 1'b1;
        tl.push_back(r);
    endtask

    task automatic step(input logic st, input logic ab);
        rec_t cur, r;
        start = st;
        abort = ab;
        if (tl.size() > 0) cur = tl.pop_front();
        else cur = idle_rec();
        exp_q.push_back(cur);
        if (ab) begin
            tl.delete();
            loading = 1'b0;
        end else if (loading) begin
            loading = 1'b0;
            build_run();
        end else if (st && !cur.busy) begin
            r = idle_rec();
            r.busy = 1'b1;
            tl.push_back(r);
            loading = 1'b1;
        end
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic set_cfg(input int c, input int r);
        count = CW'(c);
        q     = CW'(r);
    endtask

    task automatic set_ch(input int k, input int u, input int d);
        time_up[k*TW +: TW]   = TW'(u);
        time_down[k*TW +: TW] = TW'(d);
    endtask

    initial begin
        rec_t e;
        forever begin
            @(negedge wb_clk_i or posedge wb_rst_i);
            if (wb_rst_i) begin
                #1;
                checks++;
                if ({rst_o, phase_out, busy, done, err, frame_idx} !== {(NCH+CW+4){1'b0}}) begin
                    failures++;
                    $display("FAIL reset_clear t=%0t got rst=%b ph=%b busy=%b done=%b err=%b fidx=%0d need all 0",
                             $time, rst_o, phase_out, busy, done, err, frame_idx);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rst_o !== e.rst_o || phase_out !== e.phase || busy !== e.busy ||
                    done !== e.done || err !== e.err || (e.run && frame_idx !== e.fidx)) begin
                    failures++;
                    $display("FAIL cycle_out t=%0t got rst=%b ph=%b busy=%b done=%b err=%b fidx=%0d need rst=%b ph=%b busy=%b done=%b err=%b fidx=%0d",
                             $time, rst_o, phase_out, busy, done, err, frame_idx,
                             e.rst_o, e.phase, e.busy, e.done, e.err, e.fidx);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b0;
        step(0, 0);

        // Basic run with degenerate and overlong windows, then ignored mid-run changes
        set_cfg(10, 2);
        set_ch(0, 2, 5);
        set_ch(1, 7, 3);
        set_ch(2, 4, 4);
        set_ch(3, 8, 2000);
        set_ch(4, 0, 10);
        set_ch(5, 9, 12);
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 24; i++) begin
            if (i == 3) begin
                set_ch(0, 0, 9);
                count = 12'd3;
            end
            step(i == 5 || i == 12, 0);
        end

        // Rejected runs, including a start accepted in the err cycle
        set_cfg(0, 3);
        step(1, 0);
        step(0, 0);
        set_cfg(4, 2);
        step(1, 0);
        repeat (12) step(0, 0);
        set_cfg(5, 0);
        step(1, 0);
        repeat (3) step(0, 0);

        // Abort in frame 1 at cnt 5, then start+abort together in IDLE
        set_cfg(10, 3);
        step(1, 0);
        repeat (16) step(0, 0);
        step(0, 1);
        step(1, 1);
        repeat (3) step(0, 0);

        // Start held high: runs back-to-back with one idle cycle between
        set_cfg(3, 1);
        repeat (14) step(1, 0);
        step(0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                set_cfg($urandom_range(0, 12), $urandom_range(0, 3));
                for (int k = 0; k < NCH; k++)
                    set_ch(k, $urandom_range(0, 15),
                           ($urandom_range(0, 7) == 0) ? 2000 : $urandom_range(0, 15));
            end
            step($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        end
        repeat (40) step(0, 0);

        // Asynchronous reset mid-frame, then recovery
        set_cfg(20, 2);
        set_ch(0, 0, 20);
        step(1, 0);
        repeat (8) step(0, 0);
        wb_rst_i = 1'b1;
        tl.delete();
        loading = 1'b0;
        repeat (2) begin
            @(posedge wb_clk_i);
            #2;
        end
        wb_rst_i = 1'b0;
        set_cfg(2, 2);
        step(1, 0);
        repeat (8) step(0, 0);

        @(negedge wb_clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rlbp_phase_sequencer.md
# rlbp_phase_sequencer

Frame-level timing controller for the RLBP pixel/readout datapath. It turns the Wishbone-programmed window registers (time_up/time_down per channel, frame length, frame repeat count) into the pixel reset pulse and the six phase-control outputs (out_1..out_5, out_7). It runs a programmable number of frames on a start command and reports busy, done and configuration errors. It sits between the Wishbone register file of the RLBP macro and the pixel control pins.

## Interface
Parameters:
- NCH, 6, number of phase channels (bit k maps to out_1..out_5, out_7 in that order)
- TW, 11, width of each time_up/time_down value
- CW, 12, width of the frame counter, count and q

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE only
- abort  in  1  stop immediately, return to IDLE
- time_up  in  NCH*TW  channel k rising time, bits [k*TW +: TW]
- time_down  in  NCH*TW  channel k falling time, same packing
- count  in  CW  frame length in cycles
- q  in  CW  number of frames per run
- rst_o  out  1  pixel reset, high in cycle cnt==0 of every frame
- phase_out  out  NCH  channel windows
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse at normal run completion
- err  out  1  one-cycle pulse when a run is rejected
- frame_idx  out  CW  index of the current frame (0-based)

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if abort is high, stay in IDLE. Else if start is high, go to LOAD.
- LOAD: latch time_up, time_down, count and q into shadow registers. Later input changes have no effect until the next LOAD.
  - If latched count==0 or q==0: pulse err and return to IDLE; done does not pulse.
  - Otherwise: go to RUN with cnt=0 and frame_idx=0.
- RUN: cnt increments each cycle.
  - At cnt==count-1 with frame_idx<q-1: cnt wraps to 0 and frame_idx increments.
  - At cnt==count-1 with frame_idx==q-1: go to DONE.
- DONE: pulse done, then go to IDLE.
- Window rule: in every RUN cycle, phase_out[k] == (up_k <= cnt) && (cnt < down_k). TW values are zero-extended to CW before comparison.
  - If up_k >= down_k, the channel stays low for the whole run.
  - If down_k > count, the channel stays high to the end of each frame and does not carry into the next frame.
- rst_o is high exactly in RUN cycles with cnt==0.
- phase_out and rst_o are low in IDLE, LOAD and DONE.
- start while busy is ignored.
- abort in any state: next state is IDLE, all outputs low, no done, no err.
- abort and start high together: abort wins.
- wb_rst_i, including mid-run: asynchronously clears state to IDLE, cnt, frame_idx and all shadow registers to 0.

## Timing
- Every output is a register output. Reset value of every output is 0.
- Start at edge 0 → LOAD in cycle 1 → first RUN cycle (cnt=0, rst_o=1) in cycle 2.
- A run lasts count*q RUN cycles. done is high in cycle 2+count*q. busy covers cycles 1 through 2+count*q.
- Rejected run: err is high in cycle 2, and busy is high in cycle 1 only.
- abort sampled at edge n: outputs are low from cycle n+1.
- The next start is accepted from the first IDLE cycle after DONE, so runs can be back-to-back with a gap of 1 cycle.

## Structure
- Package rlbp_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - default NCH, TW and CW;
  - the channel-to-output index constants mapping k=0..5 to out_1, out_2, out_3, out_4, out_5, out_7.
- Sub-module rlbp_phase_window: one instance per channel, generated NCH times. Inputs are the latched up/down values and cnt. The output is the registered window bit, plus an enable that forces it low outside RUN.
- Top level: the FSM, the frame counter, the repeat counter and the rst_o/err/done logic.

## Test plan
- count=10, q=2, ch0 up=2 down=5: phase_out[0] is high for cnt 2–4 in both frames; rst_o is high in cycles 2 and 12; done is high in cycle 22; busy is high in cycles 1–22.
- ch1 up=7 down=3 and ch2 up=4 down=4: both stay 0 for the whole run. ch3 up=8 down=2000 with count=10: high for cnt 8–9 of each frame and low at each cnt==0.
- count=0 (or q=0): err pulses in cycle 2; done, rst_o and phase_out never assert; a following valid start runs normally.
- count=10, q=3, abort during frame 1 at cnt=5: next cycle is IDLE with all outputs 0 and no done. A start asserted together with abort in IDLE is ignored.
- Change time_up/count inputs and assert start during RUN: timing follows the originally latched values and no restart occurs. wb_rst_i asserted mid-frame clears every output immediately, without waiting for a clock edge.
